// File: rtl/io_ready_seq_if.sv
// Bus bundle between the FSB/decoder/I-O environment and io_ready_seq.
// slave = sequencer view, master = environment view.
interface io_ready_seq_if;
  logic ASActive;
  logic ASInactive;
  logic nWE;
  logic RAMCS;
  logic ROMCS;
  logic IOCS;
  logic TimeoutB;
  logic IOACK;
  logic IOREQ;
  logic IOWR;
  logic Ready;
  logic BusErr;
  logic IOBusy;

  modport slave (
    input  ASActive, ASInactive, nWE, RAMCS, ROMCS, IOCS, TimeoutB, IOACK,
    output IOREQ, IOWR, Ready, BusErr, IOBusy
  );

  modport master (
    output ASActive, ASInactive, nWE, RAMCS, ROMCS, IOCS, TimeoutB, IOACK,
    input  IOREQ, IOWR, Ready, BusErr, IOBusy
  );
endinterface

// File: rtl/io_ready_seq.sv
// Bus-cycle sequencer deciding when FSB Ready may assert for RAM, ROM and I/O accesses.
// Define IO_WRITE_POST_EN to post I/O writes (Ready on the IOREQ-rise edge).
module io_ready_seq #(
  parameter int unsigned ROMWS = 2
) (
  input  logic           FCLK,
  input  logic           Reset,
  io_ready_seq_if.slave  bus
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] RomLoad = (ROMWS == 0) ? '0 : CW'(ROMWS - 1);
`ifdef IO_WRITE_POST_EN
  localparam bit PostEn = 1'b1;
`else
  localparam bit PostEn = 1'b0;
`endif

  // ACPT decodes the selects latched at acceptance, giving the one-cycle RAM latency
  typedef enum logic [2:0] {
    S_IDLE, S_ACPT, S_ROMW, S_IOQ, S_IOW, S_UNMAP, S_DONE
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_sel, w_sel;
  logic          r_ready, w_ready;
  logic          r_buserr, w_buserr;
  logic          r_ioreq, w_ioreq;
  logic          r_iowr, w_iowr;
  logic          r_iobusy, w_iobusy;
  logic          w_can_raise;

  always_ff @(posedge FCLK) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_ready  <= 1'b0;
      r_buserr <= 1'b0;
      r_ioreq  <= 1'b0;
      r_iowr   <= 1'b0;
      r_iobusy <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_sel    <= w_sel;
      r_ready  <= w_ready;
      r_buserr <= w_buserr;
      r_ioreq  <= w_ioreq;
      r_iowr   <= w_iowr;
      r_iobusy <= w_iobusy;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_sel       = r_sel;
    w_ready     = r_ready;
    w_buserr    = r_buserr;
    w_ioreq     = r_ioreq;
    w_iowr      = r_iowr;
    w_iobusy    = r_iobusy;
    w_can_raise = !r_iobusy && !bus.IOACK;

    // Handshake retires on its own, independent of which cycle the FSM is in
    if (r_ioreq && bus.IOACK) w_ioreq = 1'b0;
    if (r_iobusy && !r_ioreq && !bus.IOACK) w_iobusy = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.ASActive) begin
          w_sel   = {bus.RAMCS, bus.ROMCS, bus.IOCS};
          w_state = S_ACPT;
        end
      end
      S_ACPT: begin
        if (r_sel[2]) begin
          w_ready = 1'b1;
          w_state = S_DONE;
        end else if (r_sel[1]) begin
          if (ROMWS == 0) begin
            w_ready = 1'b1;
            w_state = S_DONE;
          end else begin
            w_cnt   = RomLoad;
            w_state = S_ROMW;
          end
        end else if (r_sel[0]) begin
          w_state = S_IOQ;
        end else begin
          w_state = S_UNMAP;
        end
      end
      S_ROMW: begin
        if (r_cnt == '0) begin
          w_ready = 1'b1;
          w_state = S_DONE;
        end else if (bus.TimeoutB) begin
          w_ready  = 1'b1;
          w_buserr = 1'b1;
          w_state  = S_DONE;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_IOQ: begin
        // A posted write completes cleanly even if the timeout fires on the same edge
        if (w_can_raise && PostEn && !bus.nWE) begin
          w_ioreq  = 1'b1;
          w_iowr   = 1'b1;
          w_iobusy = 1'b1;
          w_ready  = 1'b1;
          w_state  = S_DONE;
        end else if (bus.TimeoutB) begin
          w_ready  = 1'b1;
          w_buserr = 1'b1;
          w_state  = S_DONE;
        end else if (w_can_raise) begin
          w_ioreq  = 1'b1;
          w_iowr   = !bus.nWE;
          w_iobusy = 1'b1;
          w_state  = S_IOW;
        end
      end
      S_IOW: begin
        if (bus.IOACK) begin
          w_ready = 1'b1;
          w_state = S_DONE;
        end else if (bus.TimeoutB) begin
          w_ready  = 1'b1;
          w_buserr = 1'b1;
          w_state  = S_DONE;
        end
      end
      S_UNMAP: begin
        if (bus.TimeoutB) begin
          w_ready  = 1'b1;
          w_buserr = 1'b1;
          w_state  = S_DONE;
        end
      end
      S_DONE: begin
        w_state = S_DONE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // End of bus cycle overrides everything except the background handshake
    if (bus.ASInactive) begin
      w_state  = S_IDLE;
      w_ready  = 1'b0;
      w_buserr = 1'b0;
    end
  end

  assign bus.Ready  = r_ready;
  assign bus.BusErr = r_buserr;
  assign bus.IOREQ  = r_ioreq;
  assign bus.IOWR   = r_iowr;
  assign bus.IOBusy = r_iobusy;

endmodule
